// File: rtl/pll_reconfig_ctrl_pkg.sv
// pll_ctrl_pkg: types and widths shared by the PLL reconfiguration controller,
// its APB interface and the bench.
//   state_e     - controller sequencer states
//   APB_ADDR_W  - APB address width seen by the PLL register file
//   APB_DATA_W  - APB data width of a PLL register
package pll_ctrl_pkg;

    localparam int APB_ADDR_W = 5;
    localparam int APB_DATA_W = 16;

    typedef enum logic [3:0] {
        ST_PWD       = 4'd0,
        ST_RST       = 4'd1,
        ST_WAIT_LOCK = 4'd2,
        ST_LOCKED    = 4'd3,
        ST_WR_SETUP  = 4'd4,
        ST_WR_ACC    = 4'd5,
        ST_RD_SETUP  = 4'd6,
        ST_RD_ACC    = 4'd7,
        ST_ERR       = 4'd8
    } state_e;

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// pll_reconfig_ctrl_if: APB link between the controller (master) and the
// PLL reconfiguration port (slave).
//   apb_sel/apb_en/apb_write - APB phase and direction control (master -> slave)
//   apb_addr/apb_wdata       - register address and write data (master -> slave)
//   apb_ready/apb_rdata      - transfer completion and read data (slave -> master)
interface pll_reconfig_ctrl_if;
    import pll_ctrl_pkg::*;

    logic                  apb_sel;
    logic                  apb_en;
    logic                  apb_write;
    logic [APB_ADDR_W-1:0] apb_addr;
    logic [APB_DATA_W-1:0] apb_wdata;
    logic                  apb_ready;
    logic [APB_DATA_W-1:0] apb_rdata;

    modport master (
        output apb_sel, apb_en, apb_write, apb_addr, apb_wdata,
        input  apb_ready, apb_rdata
    );

    modport slave (
        input  apb_sel, apb_en, apb_write, apb_addr, apb_wdata,
        output apb_ready, apb_rdata
    );

endinterface

// File: rtl/pll_reconfig_ctrl_sync.sv
// pll_lock_sync: two-flop synchronizer bringing the PLL's asynchronous lock
// indication into the APB clock domain.
//   clk     - destination clock
//   rst     - asynchronous active-high reset, clears both flops to 0
//   async_i - raw asynchronous input
//   sync_o  - synchronized output, two clk cycles of latency
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; the first stage may go metastable and gets a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: owns the PLL power-down, reset and APB reconfiguration
// pins. Runs power-down -> reset -> wait-for-lock at power-up and after lock
// loss, and on request rewrites a register table over APB with read-back
// verification before relocking.
//   clk, rst      - APB clock, asynchronous active-high reset
//   cfg_req_i     - single-cycle reconfiguration request (LOCKED or ERR only)
//   tbl_idx_o     - table entry currently being written/read
//   tbl_addr_i    - PLL register address for tbl_idx_o (combinational from parent)
//   tbl_data_i    - PLL register value for tbl_idx_o (combinational from parent)
//   cfg_busy_o    - a sequence is in progress
//   cfg_done_o    - one-cycle pulse: reconfiguration relocked
//   cfg_err_o     - one-cycle pulse on entering ERR
//   locked_o      - PLL locked and controller idle
//   lock_lost_o   - one-cycle pulse: lock dropped while LOCKED
//   pll_pwd_o     - PLL power-down
//   pll_rst_o     - PLL reset
//   pll_lock_i    - raw PLL lock, asynchronous
//   apb           - APB master port
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int NUM_WR       = 4,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_req_i,
    output logic [3:0]            tbl_idx_o,
    input  logic [APB_ADDR_W-1:0] tbl_addr_i,
    input  logic [APB_DATA_W-1:0] tbl_data_i,
    output logic                  cfg_busy_o,
    output logic                  cfg_done_o,
    output logic                  cfg_err_o,
    output logic                  locked_o,
    output logic                  lock_lost_o,
    output logic                  pll_pwd_o,
    output logic                  pll_rst_o,
    input  logic                  pll_lock_i,
    pll_reconfig_ctrl_if.master   apb
);

    localparam int HOLD_W  = $clog2(RST_HOLD);
    localparam int TMR_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(LOCK_TIMEOUT);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [3:0]         IDX_LAST  = 4'(NUM_WR - 1);

    state_e               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [3:0]           idx_q, idx_d;
    logic                 cfg_mode_q, cfg_mode_d;   // current relock was started by a reconfiguration
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 lost_q, lost_d;
    logic                 pwd_q, pwd_d;
    logic                 prst_q, prst_d;
    logic                 busy_q, busy_d;
    logic                 locked_q, locked_d;
    logic                 sel_q, sel_d;
    logic                 en_q, en_d;
    logic                 write_q, write_d;
    logic                 lock_s;

    pll_lock_sync u_lock_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pll_lock_i),
        .sync_o  (lock_s)
    );

    // Sequencer next-state, retry/index bookkeeping and event pulses.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        idx_d      = idx_q;
        cfg_mode_d = cfg_mode_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        lost_d     = 1'b0;
        hold_d     = hold_q;
        timer_d    = timer_q;

        case (state_q)
            ST_PWD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RST;
                end else begin
                    state_d = ST_PWD;
                end
            end
            ST_RST: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_RST;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen in the same cycle as the timeout still counts as success.
                if (lock_s) begin
                    state_d    = ST_LOCKED;
                    done_d     = cfg_mode_q;
                    cfg_mode_d = 1'b0;
                end else if (timer_q == TMR_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_RST;
                    end else begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        cfg_mode_d = 1'b0;
                    end
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_LOCKED: begin
                // Lock loss takes priority; a coincident request is dropped.
                if (!lock_s) begin
                    lost_d  = 1'b1;
                    retry_d = {RETRY_W{1'b0}};
                    state_d = ST_RST;
                end else if (cfg_req_i) begin
                    idx_d      = 4'd0;
                    cfg_mode_d = 1'b1;
                    state_d    = ST_WR_SETUP;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_ACC;
            end
            ST_WR_ACC: begin
                if (apb.apb_ready) begin
                    state_d = ST_RD_SETUP;
                end else begin
                    state_d = ST_WR_ACC;
                end
            end
            ST_RD_SETUP: begin
                state_d = ST_RD_ACC;
            end
            ST_RD_ACC: begin
                if (apb.apb_ready) begin
                    if (apb.apb_rdata != tbl_data_i) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        cfg_mode_d = 1'b0;
                    end else if (idx_q == IDX_LAST) begin
                        retry_d = {RETRY_W{1'b0}};
                        state_d = ST_RST;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_WR_SETUP;
                    end
                end else begin
                    state_d = ST_RD_ACC;
                end
            end
            ST_ERR: begin
                if (cfg_req_i) begin
                    retry_d = {RETRY_W{1'b0}};
                    state_d = ST_PWD;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_PWD;
            end
        endcase

        // Both counters restart on every state change and saturate otherwise,
        // so each hold/timeout window is measured from state entry and never wraps.
        if (state_d != state_q) begin
            hold_d  = {HOLD_W{1'b0}};
            timer_d = {TMR_W{1'b0}};
        end else begin
            hold_d  = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_W'(1);
            timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
        end
    end

    // Pin levels decoded from the next state so they register together with it.
    always_comb begin
        pwd_d    = 1'b0;
        prst_d   = 1'b1;
        busy_d   = 1'b1;
        locked_d = 1'b0;
        sel_d    = 1'b0;
        en_d     = 1'b0;
        write_d  = 1'b0;
        case (state_d)
            ST_PWD:       pwd_d = 1'b1;
            ST_RST:       prst_d = 1'b1;
            ST_WAIT_LOCK: prst_d = 1'b0;
            ST_LOCKED: begin
                prst_d   = 1'b0;
                busy_d   = 1'b0;
                locked_d = 1'b1;
            end
            ST_WR_SETUP: begin
                sel_d   = 1'b1;
                write_d = 1'b1;
            end
            ST_WR_ACC: begin
                sel_d   = 1'b1;
                en_d    = 1'b1;
                write_d = 1'b1;
            end
            ST_RD_SETUP:  sel_d = 1'b1;
            ST_RD_ACC: begin
                sel_d = 1'b1;
                en_d  = 1'b1;
            end
            ST_ERR:       busy_d = 1'b0;
            default:      pwd_d = 1'b1;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_PWD;
            hold_q     <= {HOLD_W{1'b0}};
            timer_q    <= {TMR_W{1'b0}};
            retry_q    <= {RETRY_W{1'b0}};
            idx_q      <= 4'd0;
            cfg_mode_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            lost_q     <= 1'b0;
            pwd_q      <= 1'b1;
            prst_q     <= 1'b1;
            busy_q     <= 1'b1;
            locked_q   <= 1'b0;
            sel_q      <= 1'b0;
            en_q       <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            idx_q      <= idx_d;
            cfg_mode_q <= cfg_mode_d;
            done_q     <= done_d;
            err_q      <= err_d;
            lost_q     <= lost_d;
            pwd_q      <= pwd_d;
            prst_q     <= prst_d;
            busy_q     <= busy_d;
            locked_q   <= locked_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            write_q    <= write_d;
        end
    end

    assign tbl_idx_o   = idx_q;
    assign cfg_busy_o  = busy_q;
    assign cfg_done_o  = done_q;
    assign cfg_err_o   = err_q;
    assign locked_o    = locked_q;
    assign lock_lost_o = lost_q;
    assign pll_pwd_o   = pwd_q;
    assign pll_rst_o   = prst_q;

    assign apb.apb_sel   = sel_q;
    assign apb.apb_en    = en_q;
    assign apb.apb_write = write_q;
    // The table is a combinational lookup of the registered index, so address
    // and data are already stable for the whole transfer; they are gated to
    // zero outside transfers and follow the async reset through sel_q.
    assign apb.apb_addr  = sel_q ? tbl_addr_i : {APB_ADDR_W{1'b0}};
    assign apb.apb_wdata = sel_q ? tbl_data_i : {APB_DATA_W{1'b0}};

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl: directed scenarios push expected APB
// transfers and event pulses into queues; a negedge monitor pops and compares.
module tb_pll_reconfig_ctrl;
    import pll_ctrl_pkg::*;

    localparam int NUM_WR       = 4;
    localparam int RST_HOLD     = 16;
    localparam int LOCK_TIMEOUT = 200;
    localparam int MAX_RETRY    = 3;
    localparam int EVT_DONE = 1;
    localparam int EVT_ERR  = 2;
    localparam int EVT_LOST = 3;

    typedef struct {
        bit          write;
        logic [4:0]  addr;
        logic [15:0] data;
    } apb_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0;
    logic        pll_lock;
    logic [3:0]  tbl_idx;
    logic [4:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        cfg_busy, cfg_done, cfg_err, locked, lock_lost, pll_pwd, pll_rst;

    logic [4:0]  tbl_a [16];
    logic [15:0] tbl_d [16];
    logic [15:0] mem [32];
    bit          ready_mode = 1'b1;
    bit          corrupt = 1'b0;
    bit          drop = 1'b0;
    int          lock_delay = 99;
    int          lock_cnt = 0;
    logic        lock_raw = 1'b0;

    int checks = 0;
    int errors = 0;
    apb_exp_t exp_apb[$];
    int       exp_evt[$];
    apb_exp_t mon_e;
    int       mon_code;
    int       n, n_pwd;

    pll_reconfig_ctrl_if apb_if();

    pll_reconfig_ctrl #(
        .NUM_WR(NUM_WR), .RST_HOLD(RST_HOLD),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .cfg_req_i(cfg_req), .tbl_idx_o(tbl_idx),
        .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data), .cfg_busy_o(cfg_busy),
        .cfg_done_o(cfg_done), .cfg_err_o(cfg_err), .locked_o(locked),
        .lock_lost_o(lock_lost), .pll_pwd_o(pll_pwd), .pll_rst_o(pll_rst),
        .pll_lock_i(pll_lock), .apb(apb_if)
    );

    always #5 clk = ~clk;

    assign tbl_addr = tbl_a[tbl_idx];
    assign tbl_data = tbl_d[tbl_idx];

    // Zero-wait echoing APB slave; corrupt flips bit 0 of reads from table entry 2.
    assign apb_if.apb_ready = ready_mode;
    assign apb_if.apb_rdata = mem[apb_if.apb_addr] ^
                              ((corrupt && apb_if.apb_addr == tbl_a[2]) ? 16'h0001 : 16'h0000);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
        end else if (apb_if.apb_sel && apb_if.apb_en && apb_if.apb_write && apb_if.apb_ready) begin
            mem[apb_if.apb_addr] <= apb_if.apb_wdata;
        end
    end

    // PLL lock model: lock rises lock_delay+1 cycles after pwd/rst release (-1: never).
    always @(posedge clk) begin
        if (pll_pwd || pll_rst) begin
            lock_cnt <= 0;
            lock_raw <= 1'b0;
        end else if (lock_delay >= 0 && lock_cnt >= lock_delay) begin
            lock_raw <= 1'b1;
        end else begin
            lock_cnt <= lock_cnt + 1;
        end
    end
    assign pll_lock = lock_raw & ~drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes an APB transfer or pulses an event.
    always @(negedge clk) begin
        if (!rst) begin
            if (apb_if.apb_sel && apb_if.apb_en && apb_if.apb_ready) begin
                if (exp_apb.size() == 0) begin
                    chk("apb_unexpected", {apb_if.apb_write, apb_if.apb_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_apb.pop_front();
                    chk("apb_dir_addr", {apb_if.apb_write, apb_if.apb_addr}, {mon_e.write, mon_e.addr});
                    if (mon_e.write) chk("apb_wdata", apb_if.apb_wdata, mon_e.data);
                    chk("apb_pll_rst_high", pll_rst, 1'b1);
                end
            end
            if (cfg_done || cfg_err || lock_lost) begin
                mon_code = cfg_done ? EVT_DONE : (cfg_err ? EVT_ERR : EVT_LOST);
                if (exp_evt.size() == 0) begin
                    chk("evt_unexpected", mon_code, 0);
                end else begin
                    chk("evt_code", mon_code, exp_evt.pop_front());
                end
            end
        end
    end

    function automatic logic sig(input int s);
        case (s)
            0: return pll_pwd;
            1: return pll_rst;
            2: return locked;
            3: return cfg_busy;
            4: return pll_lock;
            default: return 1'b0;
        endcase
    endfunction

    // Count rising clock edges until the selected signal equals v; -1 if the budget expires.
    task automatic cycles_until(input int s, input logic v, input int budget, output int cnt);
        cnt = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (sig(s) === v) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic pulse_req();
        cfg_req = 1'b1;
        @(posedge clk); #1;
        cfg_req = 1'b0;
    endtask

    task automatic push_apb(input bit w, input int k);
        exp_apb.push_back('{w, tbl_a[k], tbl_d[k]});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl_a[i] = 5'(i);
            tbl_d[i] = 16'h0000;
        end
        tbl_a[0] = 5'h03; tbl_d[0] = 16'h1234;
        tbl_a[1] = 5'h0A; tbl_d[1] = 16'hA5A5;
        tbl_a[2] = 5'h11; tbl_d[2] = 16'h0F0F;
        tbl_a[3] = 5'h1C; tbl_d[3] = 16'hBEEF;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values, before the first edge after release
        chk("rst_pwd", pll_pwd, 1'b1);
        chk("rst_pll_rst", pll_rst, 1'b1);
        chk("rst_busy", cfg_busy, 1'b1);
        chk("rst_idx", tbl_idx, 4'd0);
        chk("rst_flags", {locked, cfg_done, cfg_err, lock_lost}, 4'b0000);
        chk("rst_apb", {apb_if.apb_sel, apb_if.apb_en, apb_if.apb_write, apb_if.apb_addr, apb_if.apb_wdata}, 32'd0);

        // Power-up: pwd falls at 16, rst at 32, lock 100 cycles later, locked 3 after that
        cycles_until(0, 1'b0, 40, n_pwd);
        chk("pwd_fall", n_pwd, 16);
        cycles_until(1, 1'b0, 40, n);
        chk("rst_fall", n_pwd + n, 32);
        cycles_until(4, 1'b1, 150, n);
        chk("lock_rise", n, 100);
        cycles_until(2, 1'b1, 10, n);
        chk("lock_to_locked", n, 3);
        chk("pwrup_busy", cfg_busy, 1'b0);

        // Reconfiguration: 4 write/read pairs, relock, one cfg_done
        lock_delay = 10;
        for (int k = 0; k < NUM_WR; k++) begin
            push_apb(1'b1, k);
            push_apb(1'b0, k);
        end
        exp_evt.push_back(EVT_DONE);
        pulse_req();
        chk("req_cycle1", {cfg_busy, pll_rst, apb_if.apb_sel, apb_if.apb_en, apb_if.apb_write}, 5'b11101);
        chk("req_addr0", apb_if.apb_addr, 5'h03);
        cycles_until(2, 1'b1, 200, n);
        chk("reconf_relock", n, 46);
        chk("reconf_done_pulse", cfg_done, 1'b1);

        // Read-back mismatch on entry 2
        tbl_d[0] = 16'h1111; tbl_d[1] = 16'h2222; tbl_d[2] = 16'h3333; tbl_d[3] = 16'h4444;
        corrupt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_apb(1'b1, k);
            push_apb(1'b0, k);
        end
        exp_evt.push_back(EVT_ERR);
        pulse_req();
        cycles_until(3, 1'b0, 50, n);
        chk("mm_err_cycle", n, 12);
        chk("mm_err_pins", {cfg_err, pll_rst, pll_pwd, apb_if.apb_sel}, 4'b1100);
        repeat (20) @(posedge clk);
        #1;
        chk("mm_err_hold", {cfg_busy, locked, pll_rst}, 3'b001);
        corrupt = 1'b0;

        // Restart from ERR at PWD, lock never comes: 4 windows then ERR
        lock_delay = -1;
        exp_evt.push_back(EVT_ERR);
        pulse_req();
        chk("err_restart_pwd", {pll_pwd, pll_rst, cfg_busy}, 3'b111);
        cycles_until(1, 1'b0, 100, n);
        chk("to_first_release", n, 32);
        for (int w = 0; w < 4; w++) begin
            cycles_until(1, 1'b1, 300, n);
            chk("to_window", n, LOCK_TIMEOUT);
            if (w < 3) begin
                cycles_until(1, 1'b0, 50, n);
                chk("to_gap", n, RST_HOLD);
            end
        end
        chk("to_err", {cfg_err, cfg_busy, pll_pwd}, 3'b100);

        // Recover from ERR
        lock_delay = 10;
        pulse_req();
        cycles_until(2, 1'b1, 200, n);
        chk("recover_locked", n, 46);

        // Lock drop for 5 cycles with cfg_req on the sync edge: lock loss wins
        exp_evt.push_back(EVT_LOST);
        drop = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_req = 1'b1;
        @(posedge clk); #1;
        cfg_req = 1'b0;
        chk("loss_pins", {lock_lost, pll_rst, locked, cfg_busy, apb_if.apb_sel}, 5'b11010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drop = 1'b0;
        cycles_until(2, 1'b1, 200, n);
        chk("loss_relock", n, 28);

        // Async reset while stalled in WR_ACC
        ready_mode = 1'b0;
        pulse_req();
        @(posedge clk); #1;
        chk("stall_wr_acc", {apb_if.apb_sel, apb_if.apb_en, apb_if.apb_write}, 3'b111);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_apb", {apb_if.apb_sel, apb_if.apb_en, apb_if.apb_write, apb_if.apb_addr, apb_if.apb_wdata}, 32'd0);
        chk("arst_pins", {pll_pwd, pll_rst, cfg_busy, locked, tbl_idx}, 8'b1110_0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        chk("apb_q_empty", exp_apb.size(), 0);
        chk("evt_q_empty", exp_evt.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer that owns the PLL's power-down, reset and APB reconfiguration pins. It runs the power-up sequence (power-down, then reset, then wait for lock). It re-runs that sequence if lock is lost. On request it rewrites a table of PLL registers over APB, with read-back check, then relocks. It sits beside the PLL instance and is clocked by the PLL's APB clock.

## Interface
Parameters:
- NUM_WR, 4: register writes per reconfiguration (1..16)
- RST_HOLD, 16: cycles pll_pwd and pll_rst are each held during a reset sequence (≥2)
- LOCK_TIMEOUT, 50000: cycles allowed from pll_rst release to synced lock
- MAX_RETRY, 3: relock attempts after a timeout before ERR

Ports:
- clk  in  1  system/APB clock
- rst  in  1  reset, asynchronous, active-high
- cfg_req  in  1  single-cycle start-reconfiguration pulse
- tbl_idx  out  4  current table entry index
- tbl_addr  in  5  PLL register address for tbl_idx (combinational from parent)
- tbl_data  in  16  register value for tbl_idx
- cfg_busy  out  1  sequence in progress
- cfg_done  out  1  one-cycle pulse, reconfiguration locked OK
- cfg_err  out  1  one-cycle pulse on entering ERR
- locked  out  1  PLL locked and controller idle
- lock_lost  out  1  one-cycle pulse, lock dropped while in LOCKED
- pll_pwd  out  1  PLL power-down
- pll_rst  out  1  PLL reset
- pll_lock  in  1  raw PLL lock (asynchronous)
- apb_sel, apb_en, apb_write  out  1 each  APB control
- apb_addr  out  5;  apb_wdata  out  16
- apb_ready  in  1;  apb_rdata  in  16

## Operation
- Reset values: pll_pwd=1, pll_rst=1, cfg_busy=1, tbl_idx=0, every other output 0. The state is PWD.
- pll_lock passes through a 2-FF synchronizer, giving lock_s. Every lock decision uses lock_s.
- States and transitions:
  - PWD: pwd=1, rst=1 for RST_HOLD cycles, then go to RST.
  - RST: pwd=0, rst=1 for RST_HOLD cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: rst=0 and the timer counts.
    - lock_s=1 goes to LOCKED. If this sequence was started by a reconfiguration, pulse cfg_done.
    - Timer reaches LOCK_TIMEOUT: if retry<MAX_RETRY, increment retry and go to RST; otherwise go to ERR.
  - LOCKED: locked=1, busy=0.
    - lock_s falling pulses lock_lost, clears retry and goes to RST.
    - Otherwise cfg_req asserts pll_rst, sets tbl_idx=0 and goes to WR_SETUP.
  - WR_SETUP: sel=1, en=0, write=1, addr/wdata from the table. Next state is WR_ACC.
  - WR_ACC: sel=1, en=1. Hold until apb_ready, then go to RD_SETUP.
  - RD_SETUP / RD_ACC: same handshake with write=0. On apb_ready, compare apb_rdata to tbl_data.
    - Mismatch goes to ERR.
    - Match with tbl_idx<NUM_WR-1: increment tbl_idx and go to WR_SETUP.
    - Match on the last entry: go to RST, with retry cleared.
  - ERR: pwd=0, rst=1, busy=0, locked=0. cfg_req restarts at PWD with retry cleared.
- cfg_req is ignored in every state except LOCKED and ERR; it is not queued.
- pll_rst stays 1 from cfg_req acceptance through every APB transfer.
- rst asserted mid-sequence (including mid-APB transfer) returns all outputs to reset values immediately. No APB completion is owed.

## Timing
- cfg_req sampled in LOCKED: cycle+1 gives busy=1, pll_rst=1, state WR_SETUP.
- Each APB transfer takes 2 cycles plus apb_ready wait states. apb_addr, apb_wdata and apb_write are stable from SETUP until apb_ready.
- Zero-wait APB, NUM_WR=4: 16 cycles of APB traffic, then RST_HOLD in RST.
- Lock edge to LOCKED is 2 cycles (sync) plus 1 cycle.
- Lock-loss detection is 2 cycles (sync) plus 1 cycle. lock_lost and the entry into RST happen in the same cycle.
- Timeout counter width is $clog2(LOCK_TIMEOUT+1). It clears on entry to WAIT_LOCK and saturates; it never wraps.
- cfg_req and lock_s fall in the same LOCKED cycle: lock loss wins and cfg_req is dropped.

## Structure
- Shared package pll_ctrl_pkg holds:
  - the state enum (PWD, RST, WAIT_LOCK, LOCKED, WR_SETUP, WR_ACC, RD_SETUP, RD_ACC, ERR);
  - APB widths (addr 5, data 16).
- One sub-module, pll_lock_sync: a 2-FF synchronizer with async reset to 0.

## Test plan
- Power-up, RST_HOLD=16, lock asserted 100 cycles after pll_rst falls:
  - pwd falls at cycle 16 and rst falls at cycle 32;
  - locked=1 three cycles after lock rises;
  - no cfg_done pulse.
- Reconfiguration, NUM_WR=4, zero-wait APB slave echoing writes: exactly 4 write/read pairs at table addresses, pll_rst high throughout, then one cfg_done pulse after lock.
- Read-back mismatch on entry 2: cfg_err pulses, state ERR, pll_rst=1, no further APB access. A cfg_req afterwards restarts at PWD.
- Lock never asserts, MAX_RETRY=3: 4 timeout windows separated by RST pulses, then cfg_err.
- Lock dropped for 5 cycles in LOCKED, with cfg_req in the same cycle as the sync edge: lock_lost pulses, the relock sequence runs, and no APB activity occurs.
- rst asserted during WR_ACC with apb_ready held low: all APB outputs 0, pwd=1 and rst=1 immediately.
